// File: rtl/vga_pkg.sv
// vga_pkg: shared framebuffer geometry, pixel and column-fill command types
package vga_pkg;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 200;
    localparam int ADDR_W    = 17;
    localparam int COLOR_W   = 8;

    typedef logic [COLOR_W-1:0] pixel_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] top;
        logic [7:0] bot;
        pixel_t     ceil;
        pixel_t     wall;
        pixel_t     floor;
    } fill_cmd_t;

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;
endpackage

// File: rtl/vline_fill_if.sv
// vline_fill_if: command handshake, framebuffer write bus and status of the column filler
// master: MCU / framebuffer side (drives cmd_*, fb_ready)
// slave:  fill engine side (drives cmd_ready, fb_we/addr/data, busy, done)
interface vline_fill_if;
    import vga_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x;
    logic [7:0]        cmd_top;
    logic [7:0]        cmd_bot;
    pixel_t            cmd_ceil;
    pixel_t            cmd_wall;
    pixel_t            cmd_floor;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    pixel_t            fb_data;
    logic              fb_ready;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_x, cmd_top, cmd_bot, cmd_ceil, cmd_wall, cmd_floor, fb_ready,
        input  cmd_ready, fb_we, fb_addr, fb_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_top, cmd_bot, cmd_ceil, cmd_wall, cmd_floor, fb_ready,
        output cmd_ready, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/vline_color_sel.sv
// vline_color_sel: picks ceiling, wall or floor colour for row y
// Ports: y, top, bot (unsigned rows); ceil, wall, floor colours in; color out.
// Ceiling is tested first, so top > bot yields ceiling then floor with no wall.
module vline_color_sel
    import vga_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] top,
    input  logic [7:0] bot,
    input  pixel_t     ceil,
    input  pixel_t     wall,
    input  pixel_t     floor,
    output pixel_t     color
);
    assign color = (y < top) ? ceil : (y > bot) ? floor : wall;
endmodule

// File: rtl/vline_fill.sv
// vline_fill: column-fill engine emitting one framebuffer byte write per row
// Ports: clk, reset (synchronous, active high); bus (slave modport):
//   cmd_valid/cmd_ready + cmd_* fields accept one column command in IDLE,
//   fb_we/fb_addr/fb_data write one pixel per row, held while fb_ready is low,
//   busy while not IDLE, done pulses one cycle when the column is finished.
module vline_fill
    import vga_pkg::*;
(
    input logic         clk,
    input logic         reset,
    vline_fill_if.slave bus
);
    fill_state_t state;
    fill_cmd_t   in_cmd;
    logic        accept;
    logic [7:0]  y, top, bot, sel_y, sel_top, sel_bot;
    pixel_t      ceil_c, wall_c, floor_c, sel_ceil, sel_wall, sel_floor, color;

    assign in_cmd = '{x: bus.cmd_x, top: bus.cmd_top, bot: bus.cmd_bot,
                      ceil: bus.cmd_ceil, wall: bus.cmd_wall, floor: bus.cmd_floor};
    assign accept = bus.cmd_valid && bus.cmd_ready;

    // The selector always looks one row ahead of the registered output: row 0 of the
    // incoming command while IDLE, row y+1 of the latched command while filling.
    assign sel_y     = (state == IDLE) ? 8'd0 : y + 8'd1;
    assign sel_top   = (state == IDLE) ? in_cmd.top : top;
    assign sel_bot   = (state == IDLE) ? in_cmd.bot : bot;
    assign sel_ceil  = (state == IDLE) ? in_cmd.ceil : ceil_c;
    assign sel_wall  = (state == IDLE) ? in_cmd.wall : wall_c;
    assign sel_floor = (state == IDLE) ? in_cmd.floor : floor_c;

    vline_color_sel u_sel (
        .y     (sel_y),
        .top   (sel_top),
        .bot   (sel_bot),
        .ceil  (sel_ceil),
        .wall  (sel_wall),
        .floor (sel_floor),
        .color (color)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            y             <= '0;
            bus.fb_we     <= 1'b0;
            bus.fb_addr   <= '0;
            bus.fb_data   <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    top           <= in_cmd.top;
                    bot           <= in_cmd.bot;
                    ceil_c        <= in_cmd.ceil;
                    wall_c        <= in_cmd.wall;
                    floor_c       <= in_cmd.floor;
                    y             <= '0;
                    bus.cmd_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    if (in_cmd.x >= 9'(FB_WIDTH)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state       <= FILL;
                        bus.fb_we   <= 1'b1;
                        bus.fb_addr <= ADDR_W'(in_cmd.x);
                        bus.fb_data <= color;
                    end
                end
                // Without fb_ready nothing changes, so the write is held stable.
                FILL: if (bus.fb_ready) begin
                    if (y == 8'(FB_HEIGHT - 1)) begin
                        state     <= DONE;
                        bus.fb_we <= 1'b0;
                        bus.done  <= 1'b1;
                    end else begin
                        y           <= y + 8'd1;
                        bus.fb_addr <= bus.fb_addr + ADDR_W'(FB_WIDTH);
                        bus.fb_data <= color;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vline_fill.sv
// tb_vline_fill: directed checks of the column-fill engine
module tb_vline_fill;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   rows, done_at, ready_at, nw, last_addr;

    vline_fill_if bus ();

    vline_fill dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic issue(input int x, input int top, input int bot, input int ce, input int wa, input int fl);
        bus.cmd_x     = 9'(x);
        bus.cmd_top   = 8'(top);
        bus.cmd_bot   = 8'(bot);
        bus.cmd_ceil  = 8'(ce);
        bus.cmd_wall  = 8'(wa);
        bus.cmd_floor = 8'(fl);
    endtask

    // Called just after the accepting edge; n counts edges since acceptance, so the
    // negedge sample inside iteration n observes cycle T+n.
    task automatic run_col(input int x, input int top, input int bot, input int ce, input int wa,
                           input int fl, input bit toggle, output int rows_o, output int done_o,
                           output int ready_o, output int nw_o, output int last_o);
        bit          held_v;
        logic [16:0] ha;
        logic [7:0]  hd;
        rows_o = 0; done_o = -1; ready_o = -1; nw_o = 0; last_o = -1; held_v = 0;
        ha = '0; hd = '0;
        for (int n = 1; n <= 450; n++) begin
            bus.fb_ready = toggle ? ((n % 2) == 1) : 1'b1;
            @(negedge clk);
            if (n == 1) begin
                check("busy_after_accept", 32'(bus.busy), 32'd1);
                check("ready_low_after_accept", 32'(bus.cmd_ready), 32'd0);
            end
            if (bus.fb_we && held_v) begin
                check("hold_addr", 32'(bus.fb_addr), 32'(ha));
                check("hold_data", 32'(bus.fb_data), 32'(hd));
            end
            held_v = 0;
            if (bus.fb_we && bus.fb_ready) begin
                check($sformatf("row%0d_addr", rows_o), 32'(bus.fb_addr), x + rows_o * 320);
                check($sformatf("row%0d_data", rows_o), 32'(bus.fb_data),
                      rows_o < top ? ce : rows_o > bot ? fl : wa);
                if (bus.fb_data == wa[7:0]) nw_o++;
                last_o = int'(bus.fb_addr);
                rows_o++;
            end else if (bus.fb_we) begin
                held_v = 1;
                ha = bus.fb_addr;
                hd = bus.fb_data;
            end
            if (bus.done && done_o < 0) done_o = n;
            if (done_o >= 0 && n == done_o + 1) begin
                ready_o = bus.cmd_ready ? n : -1;
                n = 1000;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic accept_edge();
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.fb_ready  = 1'b1;
        issue(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_fb_we", 32'(bus.fb_we), 32'd0);
        check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("rst_fb_data", 32'(bus.fb_data), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // plain column, no back-pressure
        issue(10, 50, 149, 'h03, 'hE0, 'h1C);
        accept_edge();
        run_col(10, 50, 149, 'h03, 'hE0, 'h1C, 0, rows, done_at, ready_at, nw, last_addr);
        check("t1_rows", rows, 200);
        check("t1_done_at", done_at, 201);
        check("t1_ready_at", ready_at, 202);
        check("t1_wall_px", nw, 100);
        check("t1_last_addr", last_addr, 63690);

        // same column, fb_ready alternating 1/0 starting with 1
        accept_edge();
        run_col(10, 50, 149, 'h03, 'hE0, 'h1C, 1, rows, done_at, ready_at, nw, last_addr);
        check("t2_rows", rows, 200);
        check("t2_done_at", done_at, 400);
        check("t2_ready_at", ready_at, 401);
        check("t2_wall_px", nw, 100);

        // inverted wall span: ceiling then floor, no wall
        issue(7, 120, 80, 'h11, 'h22, 'h33);
        accept_edge();
        run_col(7, 120, 80, 'h11, 'h22, 'h33, 0, rows, done_at, ready_at, nw, last_addr);
        check("t3_rows", rows, 200);
        check("t3_done_at", done_at, 201);
        check("t3_wall_px", nw, 0);

        // out-of-range column
        issue(320, 0, 199, 'h11, 'h22, 'h33);
        accept_edge();
        run_col(320, 0, 199, 'h11, 'h22, 'h33, 0, rows, done_at, ready_at, nw, last_addr);
        check("t4_rows", rows, 0);
        check("t4_done_at", done_at, 1);
        check("t4_ready_at", ready_at, 2);

        // reset in the middle of a fill, at row 77
        issue(10, 50, 149, 'h03, 'hE0, 'h1C);
        accept_edge();
        bus.fb_ready = 1'b1;
        repeat (77) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_pre_reset_addr", 32'(bus.fb_addr), 32'd24650);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_fb_we", 32'(bus.fb_we), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        issue(319, 0, 199, 'h44, 'h55, 'h66);
        accept_edge();
        run_col(319, 0, 199, 'h44, 'h55, 'h66, 0, rows, done_at, ready_at, nw, last_addr);
        check("t5_rows", rows, 200);
        check("t5_wall_px", nw, 200);
        check("t5_last_addr", last_addr, 63999);

        // back-to-back with cmd_valid held; fields change to the second command while busy
        @(posedge clk);
        #1;
        issue(5, 10, 20, 'h01, 'h02, 'h04);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        issue(300, 0, 0, 'hAA, 'hBB, 'hCC);
        run_col(5, 10, 20, 'h01, 'h02, 'h04, 0, rows, done_at, ready_at, nw, last_addr);
        check("t6a_rows", rows, 200);
        check("t6a_done_at", done_at, 201);
        check("t6a_ready_at", ready_at, 202);
        check("t6a_wall_px", nw, 11);
        check("t6a_last_addr", last_addr, 63685);
        bus.cmd_valid = 1'b0;
        run_col(300, 0, 0, 'hAA, 'hBB, 'hCC, 0, rows, done_at, ready_at, nw, last_addr);
        check("t6b_rows", rows, 200);
        check("t6b_done_at", done_at, 201);
        check("t6b_ready_at", ready_at, 202);
        check("t6b_wall_px", nw, 1);
        check("t6b_last_addr", last_addr, 63980);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
